// File: rtl/hir_mac_pipe_if.sv
// Operand/result bundle for the pipelined multiply-accumulate unit.
// The scheduler side is the master; the MAC datapath is the slave.
interface hir_mac_pipe_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ACC_WIDTH = 80
);
    logic                 t;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 acc_clr;
    logic [ACC_WIDTH-1:0] result;
    logic                 tout;
    logic                 ovf;

    modport master (
        output t,
        output a,
        output b,
        output acc_clr,
        input  result,
        input  tout,
        input  ovf
    );

    modport slave (
        input  t,
        input  a,
        input  b,
        input  acc_clr,
        output result,
        output tout,
        output ovf
    );
endinterface

// File: rtl/hir_mac_pipe.sv
// Fully pipelined multiply-accumulate unit, II=1, fixed LATENCY from t to tout.
// Stage 1 captures operands, stage 2 holds the full product, stages 3..LATENCY-1
// are delay, and stage LATENCY updates the accumulator and raises tout.
module hir_mac_pipe #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ACC_WIDTH  = 80,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned SIGNED     = 1,
    parameter int unsigned ACCUMULATE = 1
) (
    input logic          clk,
    input logic          rst,
    hir_mac_pipe_if.slave bus
);
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned DLY = (LATENCY > 3) ? (LATENCY - 3) : 0;

    // Elaboration-time parameter checks.
    if (WIDTH < 2) begin : g_err_width
        $error("hir_mac_pipe: WIDTH must be >= 2");
    end
    if (ACC_WIDTH < PW) begin : g_err_acc
        $error("hir_mac_pipe: ACC_WIDTH must be >= 2*WIDTH");
    end
    if (LATENCY < 3) begin : g_err_lat
        $error("hir_mac_pipe: LATENCY must be >= 3");
    end
    if ($bits(bus.a) != WIDTH || $bits(bus.result) != ACC_WIDTH) begin : g_err_if
        $error("hir_mac_pipe: interface widths do not match module parameters");
    end

    // ------------------------------------------------------------------
    // Stage 1: operand capture
    // ------------------------------------------------------------------
    logic             s1_vld_q;
    logic             s1_clr_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;

    // Valid/clr bits are reset so in-flight work is discarded on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_clr_q <= 1'b0;
        end else begin
            s1_vld_q <= bus.t;
            s1_clr_q <= bus.t & bus.acc_clr;
        end
    end

    // Operand data needs no reset; only loaded on a valid time pulse.
    always_ff @(posedge clk) begin
        if (bus.t) begin
            s1_a_q <= bus.a;
            s1_b_q <= bus.b;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: full-width product
    // ------------------------------------------------------------------
    logic [PW-1:0] mul_a;
    logic [PW-1:0] mul_b;
    logic [PW-1:0] mul_p;

    // Extend both operands to 2*WIDTH so the low half of the product is exact
    // for either signedness.
    always_comb begin
        mul_a = {{WIDTH{1'b0}}, s1_a_q};
        mul_b = {{WIDTH{1'b0}}, s1_b_q};
        if (SIGNED != 0) begin
            mul_a = {{WIDTH{s1_a_q[WIDTH-1]}}, s1_a_q};
            mul_b = {{WIDTH{s1_b_q[WIDTH-1]}}, s1_b_q};
        end
        mul_p = mul_a * mul_b;
    end

    logic          s2_vld_q;
    logic          s2_clr_q;
    logic [PW-1:0] s2_prod_q;

    // Stage 2 control bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q <= 1'b0;
            s2_clr_q <= 1'b0;
        end else begin
            s2_vld_q <= s1_vld_q;
            s2_clr_q <= s1_clr_q;
        end
    end

    // Stage 2 product register, loaded only for valid operands.
    always_ff @(posedge clk) begin
        if (s1_vld_q) begin
            s2_prod_q <= mul_p;
        end
    end

    // ------------------------------------------------------------------
    // Stages 3..LATENCY-1: pure delay
    // ------------------------------------------------------------------
    logic          last_vld;
    logic          last_clr;
    logic [PW-1:0] last_prod;

    if (DLY > 0) begin : g_dly
        logic          dly_vld_q  [DLY];
        logic          dly_clr_q  [DLY];
        logic [PW-1:0] dly_prod_q [DLY];

        // Control shift chain, cleared by reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < int'(DLY); i++) begin
                    dly_vld_q[i] <= 1'b0;
                    dly_clr_q[i] <= 1'b0;
                end
            end else begin
                dly_vld_q[0] <= s2_vld_q;
                dly_clr_q[0] <= s2_clr_q;
                for (int i = 1; i < int'(DLY); i++) begin
                    dly_vld_q[i] <= dly_vld_q[i-1];
                    dly_clr_q[i] <= dly_clr_q[i-1];
                end
            end
        end

        // Product shift chain; contents only matter alongside a valid bit.
        always_ff @(posedge clk) begin
            dly_prod_q[0] <= s2_prod_q;
            for (int i = 1; i < int'(DLY); i++) begin
                dly_prod_q[i] <= dly_prod_q[i-1];
            end
        end

        assign last_vld  = dly_vld_q[DLY-1];
        assign last_clr  = dly_clr_q[DLY-1];
        assign last_prod = dly_prod_q[DLY-1];
    end else begin : g_nodly
        assign last_vld  = s2_vld_q;
        assign last_clr  = s2_clr_q;
        assign last_prod = s2_prod_q;
    end

    // ------------------------------------------------------------------
    // Stage LATENCY: accumulate and emit
    // ------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] ext_prod;

    if (ACC_WIDTH > PW) begin : g_ext
        logic ext_bit;
        assign ext_bit  = (SIGNED != 0) ? last_prod[PW-1] : 1'b0;
        assign ext_prod = {{(ACC_WIDTH-PW){ext_bit}}, last_prod};
    end else begin : g_noext
        assign ext_prod = last_prod;
    end

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic                 tout_q;
    logic [ACC_WIDTH:0]   sum_full;
    logic [ACC_WIDTH-1:0] sum;
    logic                 add_ovf;

    // Next accumulator/overflow state; idle cycles hold everything.
    always_comb begin
        sum_full = {1'b0, acc_q} + {1'b0, ext_prod};
        sum      = sum_full[ACC_WIDTH-1:0];
        if (SIGNED != 0) begin
            add_ovf = (acc_q[ACC_WIDTH-1] == ext_prod[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        end else begin
            add_ovf = sum_full[ACC_WIDTH];
        end

        acc_d = acc_q;
        ovf_d = ovf_q;
        if (last_vld) begin
            if (ACCUMULATE == 0 || last_clr) begin
                acc_d = ext_prod;
                ovf_d = 1'b0;
            end else begin
                acc_d = sum;
                ovf_d = ovf_q | add_ovf;
            end
        end
    end

    // Final-stage registers; result is the accumulator itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            tout_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            tout_q <= last_vld;
        end
    end

    assign bus.result = acc_q;
    assign bus.tout   = tout_q;
    assign bus.ovf    = (ACCUMULATE != 0) ? ovf_q : 1'b0;

endmodule

// File: tb/tb_hir_mac_pipe.sv
// Bench for hir_mac_pipe: five configurations share one stimulus stream and are
// compared every cycle against a transaction-level model; directed cases pin
// hand-computed values.
module tb_hir_mac_pipe;
    localparam int ND = 5;
    // Per-instance configuration: width, acc width, latency, signed, accumulate.
    localparam int CW  [ND] = '{32, 32, 8, 32, 16};
    localparam int CAW [ND] = '{80, 80, 16, 80, 32};
    localparam int CL  [ND] = '{4, 4, 4, 6, 3};
    localparam int CS  [ND] = '{1, 0, 1, 1, 0};
    localparam int CA  [ND] = '{1, 1, 1, 0, 1};

    logic        clk = 1'b0;
    logic        rst_v;
    logic        t_v;
    logic [31:0] a_v;
    logic [31:0] b_v;
    logic        clr_v;

    always #5 clk = ~clk;

    hir_mac_pipe_if #(.WIDTH(32), .ACC_WIDTH(80)) if0 ();
    hir_mac_pipe_if #(.WIDTH(32), .ACC_WIDTH(80)) if1 ();
    hir_mac_pipe_if #(.WIDTH(8),  .ACC_WIDTH(16)) if2 ();
    hir_mac_pipe_if #(.WIDTH(32), .ACC_WIDTH(80)) if3 ();
    hir_mac_pipe_if #(.WIDTH(16), .ACC_WIDTH(32)) if4 ();

    assign if0.t = t_v;  assign if0.a = a_v;        assign if0.b = b_v;        assign if0.acc_clr = clr_v;
    assign if1.t = t_v;  assign if1.a = a_v;        assign if1.b = b_v;        assign if1.acc_clr = clr_v;
    assign if2.t = t_v;  assign if2.a = a_v[7:0];   assign if2.b = b_v[7:0];   assign if2.acc_clr = clr_v;
    assign if3.t = t_v;  assign if3.a = a_v;        assign if3.b = b_v;        assign if3.acc_clr = clr_v;
    assign if4.t = t_v;  assign if4.a = a_v[15:0];  assign if4.b = b_v[15:0];  assign if4.acc_clr = clr_v;

    hir_mac_pipe #(.WIDTH(32), .ACC_WIDTH(80), .LATENCY(4), .SIGNED(1), .ACCUMULATE(1))
        u0 (.clk(clk), .rst(rst_v), .bus(if0));
    hir_mac_pipe #(.WIDTH(32), .ACC_WIDTH(80), .LATENCY(4), .SIGNED(0), .ACCUMULATE(1))
        u1 (.clk(clk), .rst(rst_v), .bus(if1));
    hir_mac_pipe #(.WIDTH(8),  .ACC_WIDTH(16), .LATENCY(4), .SIGNED(1), .ACCUMULATE(1))
        u2 (.clk(clk), .rst(rst_v), .bus(if2));
    hir_mac_pipe #(.WIDTH(32), .ACC_WIDTH(80), .LATENCY(6), .SIGNED(1), .ACCUMULATE(0))
        u3 (.clk(clk), .rst(rst_v), .bus(if3));
    hir_mac_pipe #(.WIDTH(16), .ACC_WIDTH(32), .LATENCY(3), .SIGNED(0), .ACCUMULATE(1))
        u4 (.clk(clk), .rst(rst_v), .bus(if4));

    logic        tout_v [ND];
    logic        ovf_v  [ND];
    logic [79:0] res_v  [ND];

    assign tout_v[0] = if0.tout; assign ovf_v[0] = if0.ovf; assign res_v[0] = if0.result;
    assign tout_v[1] = if1.tout; assign ovf_v[1] = if1.ovf; assign res_v[1] = if1.result;
    assign tout_v[2] = if2.tout; assign ovf_v[2] = if2.ovf; assign res_v[2] = {64'd0, if2.result};
    assign tout_v[3] = if3.tout; assign ovf_v[3] = if3.ovf; assign res_v[3] = if3.result;
    assign tout_v[4] = if4.tout; assign ovf_v[4] = if4.ovf; assign res_v[4] = {48'd0, if4.result};

    int cmp_n = 0;
    int err_n = 0;

    // ------------------------------------------------------------------
    // Reference model: compute each result at issue time (results emerge in
    // issue order), schedule it LATENCY cycles ahead.
    // ------------------------------------------------------------------
    typedef struct {
        longint      due;
        logic [79:0] res;
        logic        ovf;
    } item_t;

    item_t       q [ND][$];
    logic [79:0] m_acc [ND];
    logic        m_ovf [ND];
    logic        e_tout [ND];
    logic [79:0] e_res [ND];
    logic        e_ovf [ND];
    longint      cyc = 0;
    bit          chk_en = 1'b0;

    function automatic logic signed [127:0] sx(input logic [127:0] v, input int aw);
        logic [127:0] m;
        m = (128'd1 << aw) - 128'd1;
        return v[aw-1] ? $signed(v | ~m) : $signed(v & m);
    endfunction

    function automatic void mstep(input int k, input logic [31:0] a, input logic [31:0] b,
                                  input logic clr);
        logic [127:0]        mw, ma, ax, bx, ext, sum;
        logic signed [127:0] s, hi, lo;
        bit                  of;
        mw  = (128'd1 << CW[k]) - 128'd1;
        ma  = (128'd1 << CAW[k]) - 128'd1;
        ax  = {96'd0, a} & mw;
        bx  = {96'd0, b} & mw;
        if (CS[k] != 0 && ax[CW[k]-1]) ax = ax | ~mw;
        if (CS[k] != 0 && bx[CW[k]-1]) bx = bx | ~mw;
        ext = (ax * bx) & ma;
        if (CA[k] == 0 || clr) begin
            m_acc[k] = ext[79:0];
            m_ovf[k] = 1'b0;
        end else begin
            sum = {48'd0, m_acc[k]} + ext;
            if (CS[k] != 0) begin
                hi = $signed((128'd1 << (CAW[k] - 1)) - 128'd1);
                lo = -hi - 1;
                s  = sx({48'd0, m_acc[k]}, CAW[k]) + sx(ext, CAW[k]);
                of = (s > hi) || (s < lo);
            end else begin
                of = (sum >= (128'd1 << CAW[k]));
            end
            m_acc[k] = sum[79:0] & ma[79:0];
            m_ovf[k] = m_ovf[k] | of;
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < ND; k++) begin
                if (rst_v) begin
                    q[k].delete();
                    m_acc[k]  = '0;
                    m_ovf[k]  = 1'b0;
                    e_tout[k] = 1'b0;
                    e_res[k]  = '0;
                    e_ovf[k]  = 1'b0;
                end else begin
                    e_tout[k] = 1'b0;
                    if (q[k].size() > 0 && q[k][0].due == cyc) begin
                        e_tout[k] = 1'b1;
                        e_res[k]  = q[k][0].res;
                        e_ovf[k]  = q[k][0].ovf;
                        void'(q[k].pop_front());
                    end
                    if (t_v) begin
                        item_t it;
                        mstep(k, a_v, b_v, clr_v);
                        it.due = cyc + longint'(CL[k]) - 1;
                        it.res = m_acc[k];
                        it.ovf = m_ovf[k];
                        q[k].push_back(it);
                    end
                end
            end
            if (rst_v) chk_en = 1'b1;
        end
    end

    // Every-cycle comparison of all instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < ND; k++) begin
                    cmp_n += 3;
                    if (tout_v[k] !== e_tout[k]) begin
                        err_n++;
                        $display("FAIL cyc_tout dut%0d cyc %0d: got %b expected %b",
                                 k, cyc, tout_v[k], e_tout[k]);
                    end
                    if (res_v[k] !== e_res[k]) begin
                        err_n++;
                        $display("FAIL cyc_result dut%0d cyc %0d: got %h expected %h",
                                 k, cyc, res_v[k], e_res[k]);
                    end
                    if (ovf_v[k] !== e_ovf[k]) begin
                        err_n++;
                        $display("FAIL cyc_ovf dut%0d cyc %0d: got %b expected %b",
                                 k, cyc, ovf_v[k], e_ovf[k]);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic ti, input logic [31:0] ai, input logic [31:0] bi,
                         input logic ci, input logic ri);
        @(posedge clk);
        #1;
        t_v = ti; a_v = ai; b_v = bi; clr_v = ci; rst_v = ri;
    endtask

    task automatic pin_now(input int k, input logic [79:0] r, input logic o, input logic te,
                           input string nm);
        cmp_n++;
        if (tout_v[k] !== te || res_v[k] !== r || ovf_v[k] !== o) begin
            err_n++;
            $display("FAIL %s dut%0d: got tout=%b result=%h ovf=%b expected tout=%b result=%h ovf=%b",
                     nm, k, tout_v[k], res_v[k], ovf_v[k], te, r, o);
        end
    endtask

    task automatic pin_next(input int k, input logic [79:0] r, input logic o, input string nm);
        @(negedge clk);
        pin_now(k, r, o, 1'b1, nm);
    endtask

    task automatic pin_wait(input int k, input logic [79:0] r, input logic o, input string nm);
        int n = 0;
        @(negedge clk);
        while (!tout_v[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        pin_now(k, r, o, 1'b1, nm);
    endtask

    initial begin
        rst_v = 1'b1; t_v = 1'b0; a_v = '0; b_v = '0; clr_v = 1'b0;
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        pin_now(0, 80'd0, 1'b0, 1'b0, "reset_state");

        // Single multiply.
        drive(1, 3, 5, 1, 0);
        drive(0, 0, 0, 0, 0);
        pin_wait(0, 80'd15, 1'b0, "single_mul");

        // Back-to-back accumulation.
        drive(1, 2, 3, 1, 0);
        drive(1, 4, 5, 0, 0);
        drive(1, 1, 1, 0, 0);
        drive(1, 10, 10, 0, 0);
        drive(0, 0, 0, 0, 0);
        pin_wait(0, 80'd6, 1'b0, "b2b_0");
        pin_next(0, 80'd26, 1'b0, "b2b_1");
        pin_next(0, 80'd27, 1'b0, "b2b_2");
        pin_next(0, 80'd127, 1'b0, "b2b_3");

        // Signed vs unsigned interpretation.
        drive(1, 32'hFFFF_FFFE, 7, 1, 0);
        drive(0, 0, 0, 0, 0);
        pin_wait(0, 80'hFFFF_FFFF_FFFF_FFFF_FFF2, 1'b0, "signed_neg");
        pin_now(1, 80'd30064771058, 1'b0, 1'b1, "unsigned_big");

        // Signed overflow on 16-bit accumulator, cleared by next clr.
        drive(1, 127, 127, 1, 0);
        drive(1, 127, 127, 0, 0);
        drive(1, 127, 127, 0, 0);
        drive(1, 1, 1, 1, 0);
        drive(0, 0, 0, 0, 0);
        pin_wait(2, 80'd16129, 1'b0, "ovf_0");
        pin_next(2, 80'd32258, 1'b0, "ovf_1");
        pin_next(2, 80'h0000_0000_0000_0000_BD03, 1'b1, "ovf_wrap");
        pin_next(2, 80'd1, 1'b0, "ovf_clear");

        // Reset discards in-flight operations.
        drive(1, 9, 9, 1, 0);
        drive(1, 9, 9, 1, 0);
        drive(0, 0, 0, 0, 1);
        drive(1, 2, 2, 0, 0);
        pin_now(0, 80'd0, 1'b0, 1'b0, "rst_result");
        drive(0, 0, 0, 0, 0);
        pin_wait(0, 80'd4, 1'b0, "post_rst");

        // Plain multiplier with longer latency, result held afterwards.
        drive(1, 6, 7, 0, 0);
        drive(1, 2, 2, 0, 0);
        drive(0, 0, 0, 0, 0);
        pin_wait(3, 80'd42, 1'b0, "mul_only_0");
        pin_next(3, 80'd4, 1'b0, "mul_only_1");
        repeat (5) @(negedge clk);
        pin_now(3, 80'd4, 1'b0, 1'b0, "mul_only_hold");

        // Randomized traffic with corner operands and occasional reset.
        for (int i = 0; i < 800; i++) begin
            logic [31:0] ra, rb;
            logic [31:0] corner [4];
            corner[0] = 32'h0000_0000;
            corner[1] = 32'hFFFF_FFFF;
            corner[2] = 32'h8000_0080;
            corner[3] = 32'h7FFF_7F7F;
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            drive(($urandom_range(0, 9) < 7), ra, rb, ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 99) == 0));
        end
        repeat (10) drive(0, 0, 0, 0, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
